// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the 32 x 64-bit register file write port from the ALU and load paths.
// Define REG_WB_SCOREBOARD_EN to generate the busy_rn/busy_rm pending-write scoreboard; otherwise both tie to 0.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [4:0]              mem_rd,
    input  logic [XLEN-1:0]         mem_data,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [4:0]              alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    output logic                    rf_regwrite,
    output logic [4:0]              rf_rd,
    output logic [XLEN-1:0]         rf_writeData,
    input  logic [4:0]              rn_q,
    input  logic [4:0]              rm_q,
    output logic                    busy_rn,
    output logic                    busy_rm,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [4:0] XZR = 5'd31;

    logic [4:0]      q_rd_p0   [DEPTH];
    logic [XLEN-1:0] q_data_p0 [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   alu_slot;
    logic [CW-1:0]   free_slots;
    logic [CW-1:0]   n_enq;
    logic            mem_enq;
    logic            alu_enq;
    logic            deq;

    // Ready looks only at the registered count so a same-cycle pop never opens a slot early.
    assign free_slots = DEPTH_C - count;
    assign mem_ready  = rst_n && (free_slots != '0);
    assign alu_ready  = rst_n && ((free_slots >= CW'(2)) || ((free_slots != '0) && !mem_valid));

    // XZR results complete the handshake but are dropped here.
    assign mem_enq  = mem_valid && mem_ready && (mem_rd != XZR);
    assign alu_enq  = alu_valid && alu_ready && (alu_rd != XZR);
    assign alu_slot = wr_ptr + PW'(mem_enq);
    assign n_enq    = CW'(mem_enq) + CW'(alu_enq);
    assign deq      = (count != '0);

    // ---- enqueue stage: mem entry is older than a same-cycle alu entry
    always_ff @(posedge clk) begin
        if (mem_enq) begin
            q_rd_p0[wr_ptr]   <= mem_rd;
            q_data_p0[wr_ptr] <= mem_data;
        end
        if (alu_enq) begin
            q_rd_p0[alu_slot]   <= alu_rd;
            q_data_p0[alu_slot] <= alu_data;
        end
    end

    // ---- dequeue stage: head moves into the register-file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rf_regwrite  <= 1'b0;
            rf_rd        <= '0;
            rf_writeData <= '0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(n_enq);
            count       <= count + n_enq - CW'(deq);
            rf_regwrite <= deq;
            if (deq) begin
                rf_rd        <= q_rd_p0[rd_ptr];
                rf_writeData <= q_data_p0[rd_ptr];
                rd_ptr       <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    // Pending = any occupied queue slot or the write currently on the port; same-cycle handshakes excluded.
    always_comb begin
        busy_rn = rf_regwrite && (rf_rd == rn_q);
        busy_rm = rf_regwrite && (rf_rd == rm_q);
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if (q_rd_p0[rd_ptr + PW'(k)] == rn_q) busy_rn = 1'b1;
                if (q_rd_p0[rd_ptr + PW'(k)] == rm_q) busy_rm = 1'b1;
            end
        end
        if (rn_q == XZR) busy_rn = 1'b0;
        if (rm_q == XZR) busy_rm = 1'b0;
    end
`else
    logic sb_unused;
    assign sb_unused = ^{rn_q, rm_q};
    assign busy_rn   = 1'b0;
    assign busy_rm   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: vector table, directed corner sequences, randomized traffic vs a queue model.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef REG_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            mem_valid, mem_ready, alu_valid, alu_ready;
    logic [4:0]      mem_rd, alu_rd, rf_rd, rn_q, rm_q;
    logic [XLEN-1:0] mem_data, alu_data, rf_writeData;
    logic            rf_regwrite, busy_rn, busy_rm;
    logic [CW-1:0]   count;

    reg_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_writeData(rf_writeData),
        .rn_q(rn_q), .rm_q(rm_q), .busy_rn(busy_rn), .busy_rm(busy_rm), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        bit          is_mem;
        logic [4:0]  rd;
        logic [63:0] data;
        bit          exp_we;
        logic [4:0]  exp_rd;
        logic [63:0] exp_data;
    } vec_t;

    // Reference model: pending writes as a plain FIFO plus the expected write port.
    ent_t        mq[$];
    ent_t        acc_log[$];
    ent_t        wr_log[$];
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] x);
        if (!SB_EN || x == 5'd31) return 1'b0;
        if (exp_we && exp_rd == x) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == x) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_we   = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
    endtask

    // One clock: drive, check ready/busy/count, advance model at the edge, check write port.
    task automatic cycle(input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                         input bit av, input logic [4:0] ard, input logic [63:0] ad,
                         output bit mfire, output bit afire);
        bit   emr, ear;
        int   fr;
        ent_t e;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        #1;
        fr  = DEPTH - mq.size();
        emr = (fr >= 1);
        ear = (fr >= 2) || (fr >= 1 && !mv);
        chk("mem_ready", mem_ready, emr);
        chk("alu_ready", alu_ready, ear);
        chk("count_pre", count, mq.size());
        chk("busy_rn", busy_rn, m_busy(rn_q));
        chk("busy_rm", busy_rm, m_busy(rm_q));
        mfire = mv && emr;
        afire = av && ear;
        @(posedge clk);
        if (mq.size() > 0) begin
            e        = mq.pop_front();
            exp_we   = 1'b1;
            exp_rd   = e.rd;
            exp_data = e.data;
        end else begin
            exp_we = 1'b0;
        end
        if (mfire && mrd != 5'd31) begin
            mq.push_back('{mrd, md});
            acc_log.push_back('{mrd, md});
        end
        if (afire && ard != 5'd31) begin
            mq.push_back('{ard, ad});
            acc_log.push_back('{ard, ad});
        end
        @(negedge clk);
        chk("rf_regwrite", rf_regwrite, exp_we);
        chk("rf_rd", rf_rd, exp_rd);
        chk("rf_writeData", rf_writeData, exp_data);
        chk("count_post", count, mq.size());
        if (rf_regwrite) wr_log.push_back('{rf_rd, rf_writeData});
    endtask

    task automatic idle();
        bit mf, af;
        cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, mf, af);
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_nwrites"}, wr_log.size(), acc_log.size());
        for (int i = 0; i < wr_log.size() && i < acc_log.size(); i++) begin
            chk({tag, "_rd"}, wr_log[i].rd, acc_log[i].rd);
            chk({tag, "_data"}, wr_log[i].data, acc_log[i].data);
        end
    endtask

    vec_t vecs[6];

    initial begin
        bit         mf, af;
        int         mt, at, maxc;
        bit         pmv, pav;
        logic [4:0] pmrd, pard;
        logic [63:0] pmd, pad;

        vecs[0] = '{1'b0, 5'd5,  64'h1234,                1'b1, 5'd5,  64'h1234};
        vecs[1] = '{1'b1, 5'd12, 64'hDEAD_BEEF_0000_0001, 1'b1, 5'd12, 64'hDEAD_BEEF_0000_0001};
        vecs[2] = '{1'b0, 5'd31, 64'hFFFF,                1'b0, 5'd12, 64'hDEAD_BEEF_0000_0001};
        vecs[3] = '{1'b1, 5'd0,  64'h0,                   1'b1, 5'd0,  64'h0};
        vecs[4] = '{1'b0, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1'b1, 5'd31, 64'h55,                  1'b0, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        rn_q = '0; rm_q = '0;
        model_reset();

        // Power-on reset state
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_regwrite", rf_regwrite, 0);
        chk("rst_rd", rf_rd, 0);
        chk("rst_data", rf_writeData, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_busy", busy_rn, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_mem_ready", mem_ready, 1);
        chk("rel_alu_ready", alu_ready, 1);

        // Single-transaction vector table
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].is_mem, vecs[i].rd, vecs[i].data,
                  !vecs[i].is_mem, vecs[i].rd, vecs[i].data, mf, af);
            chk("vec_hs", vecs[i].is_mem ? mf : af, 1);
            idle();
            chk("vec_we", rf_regwrite, vecs[i].exp_we);
            chk("vec_rd", rf_rd, vecs[i].exp_rd);
            chk("vec_data", rf_writeData, vecs[i].exp_data);
            idle();
            chk("vec_we_after", rf_regwrite, 0);
        end

        // Dual accept to the same rd: mem first, alu last wins
        wr_log.delete();
        acc_log.delete();
        cycle(1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB, mf, af);
        chk("dual_hs", {mf, af}, 2'b11);
        idle();
        chk("dual_first_we", rf_regwrite, 1);
        chk("dual_first", rf_writeData, 64'hAA);
        idle();
        chk("dual_second_we", rf_regwrite, 1);
        chk("dual_second", rf_writeData, 64'hBB);
        idle();
        chk("dual_done_we", rf_regwrite, 0);
        chk("dual_nwrites", wr_log.size(), 2);
        if (wr_log.size() > 0) chk("dual_last_wins", wr_log[wr_log.size()-1].data, 64'hBB);

        // XZR discard
        rn_q = 5'd31;
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFFFF, mf, af);
        chk("xzr_hs", af, 1);
        chk("xzr_count", count, 0);
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("xzr_no_write", rf_regwrite, 0);
            chk("xzr_busy", busy_rn, 0);
        end
        rn_q = 5'd0;

        // Sustained two-source input and backpressure
        wr_log.delete();
        acc_log.delete();
        mt = 0; at = 0; maxc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 5'(mt % 16), {32'hC0DE_0000, 32'(mt)},
                  1'b1, 5'(16 + at % 15), {32'hA1A1_0000, 32'(at)}, mf, af);
            if (mf) mt++;
            if (af) at++;
            if (int'(count) > maxc) maxc = int'(count);
        end
        chk("full_bound", (maxc <= DEPTH), 1);
        chk("full_alu_throttled", (at < 10), 1);
        repeat (DEPTH + 2) idle();
        chk("full_drained", count, 0);
        compare_logs("full_order");

        // Scoreboard on rd=7
        rn_q = 5'd7;
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77, mf, af);
        chk("sb_queued", busy_rn, SB_EN ? 1 : 0);
        idle();
        chk("sb_writing_we", rf_regwrite, 1);
        chk("sb_writing", busy_rn, SB_EN ? 1 : 0);
        idle();
        chk("sb_cleared", busy_rn, 0);
        rn_q = 5'd0;

        // Reset mid-stream with three entries queued
        cycle(1'b1, 5'd9, 64'h9, 1'b1, 5'd10, 64'h10, mf, af);
        cycle(1'b1, 5'd11, 64'h11, 1'b1, 5'd12, 64'h12, mf, af);
        chk("mid_count3", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_we", rf_regwrite, 0);
        chk("mid_rst_rd", rf_rd, 0);
        chk("mid_rst_data", rf_writeData, 0);
        chk("mid_rst_mem_ready", mem_ready, 0);
        chk("mid_rst_alu_ready", alu_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_mem_ready", mem_ready, 1);
        chk("mid_rel_alu_ready", alu_ready, 1);
        idle();
        chk("mid_no_write", rf_regwrite, 0);

        // Randomized traffic with stable-hold producers
        wr_log.delete();
        acc_log.delete();
        pmv = 1'b0; pav = 1'b0;
        pmrd = '0; pard = '0; pmd = '0; pad = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pmv) begin
                pmv  = ($urandom_range(0, 2) != 0);
                pmrd = 5'($urandom_range(0, 31));
                pmd  = {$urandom(), $urandom()};
            end
            if (!pav) begin
                pav  = ($urandom_range(0, 2) != 0);
                pard = 5'($urandom_range(0, 31));
                pad  = {$urandom(), $urandom()};
            end
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                rn_q = mq[$urandom_range(0, mq.size() - 1)].rd;
            else
                rn_q = 5'($urandom_range(0, 31));
            rm_q = exp_we && $urandom_range(0, 1) == 1 ? exp_rd : 5'($urandom_range(0, 31));
            cycle(pmv, pmrd, pmd, pav, pard, pad, mf, af);
            if (mf) pmv = 1'b0;
            if (af) pav = 1'b0;
        end
        repeat (DEPTH + 2) idle();
        compare_logs("rand_order");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
